// File: rtl/axi_arbiter_pkg.sv
// axi_arbiter_pkg: shared AXI4-lite channel bundles, FSM states and response codes for the arbiter
package axi_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic              r_ready;
    logic              aw_valid;
    logic [ADDR_W-1:0] aw_addr;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic              b_ready;
  } axi_req_t;

  typedef struct packed {
    logic              ar_ready;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              aw_ready;
    logic              w_ready;
    logic              b_valid;
    logic [1:0]        b_resp;
  } axi_rsp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP
  } arb_state_e;
endpackage

// File: rtl/axi_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker; on a tie the master that did not win last time is chosen
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  // a lone requester wins outright; a tie goes to the index opposite last_i
  always_comb gnt_o = (&req_i) ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/axi_arbiter.sv
// axi_arbiter: 2:1 AXI4-lite arbiter, one outstanding transaction, round-robin between IFU (M0) and LSU (M1)
module axi_arbiter
  import axi_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  axi_req_t [1:0] m_req_i,
  output axi_rsp_t [1:0] m_rsp_o,
  output axi_req_t       s_req_o,
  input  axi_rsp_t       s_rsp_i,
  output logic [1:0]     gnt_o,
  output logic           busy_o
);
  arb_state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d, pick, req;
  logic       last_q, last_d, aw_done_q, aw_done_d, w_done_q, w_done_d, idx;
  axi_req_t   g, q;
  axi_rsp_t   r;

  assign idx    = gnt_q[1];
  assign g      = m_req_i[idx];
  assign gnt_o  = gnt_q;
  assign busy_o = state_q != IDLE;
  assign req    = {m_req_i[1].ar_valid | m_req_i[1].aw_valid | m_req_i[1].w_valid,
                   m_req_i[0].ar_valid | m_req_i[0].aw_valid | m_req_i[0].w_valid};

  rr_arb2 u_rr (
    .req_i (req),
    .last_i(last_q),
    .gnt_o (pick)
  );

  // next-state logic and per-state channel forwarding; non-current channels keep valid/ready low
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    q          = g;
    q.ar_valid = 1'b0;
    q.r_ready  = 1'b0;
    q.aw_valid = 1'b0;
    q.w_valid  = 1'b0;
    q.b_ready  = 1'b0;
    r          = s_rsp_i;
    r.ar_ready = 1'b0;
    r.r_valid  = 1'b0;
    r.aw_ready = 1'b0;
    r.w_ready  = 1'b0;
    r.b_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pick) begin
          gnt_d   = pick;
          last_d  = pick[1];
          state_d = m_req_i[pick[1]].ar_valid ? RD_ADDR : WR;
        end
      end
      RD_ADDR: begin
        q.ar_valid = g.ar_valid;
        r.ar_ready = s_rsp_i.ar_ready;
        if (g.ar_valid && s_rsp_i.ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        q.r_ready = g.r_ready;
        r.r_valid = s_rsp_i.r_valid;
        if (g.r_ready && s_rsp_i.r_valid) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      WR: begin
        q.aw_valid = g.aw_valid & ~aw_done_q;
        q.w_valid  = g.w_valid & ~w_done_q;
        r.aw_ready = s_rsp_i.aw_ready & ~aw_done_q;
        r.w_ready  = s_rsp_i.w_ready & ~w_done_q;
        aw_done_d  = aw_done_q | (q.aw_valid & s_rsp_i.aw_ready);
        w_done_d   = w_done_q | (q.w_valid & s_rsp_i.w_ready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        q.b_ready = g.b_ready;
        r.b_valid = s_rsp_i.b_valid;
        if (g.b_ready && s_rsp_i.b_valid) begin
          state_d   = IDLE;
          gnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    s_req_o = (state_q == IDLE) ? '0 : q;
    m_rsp_o = '0;
    if (state_q != IDLE) m_rsp_o[idx] = r;
  end

  // state registers; active-low synchronous reset drops any in-flight handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: directed self-checking bench for axi_arbiter
module tb_axi_arbiter;
  import axi_arbiter_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  axi_req_t [1:0] m_req;
  axi_rsp_t [1:0] m_rsp;
  axi_req_t       s_req;
  axi_rsp_t       s_rsp;
  logic [1:0]     gnt;
  logic           busy;
  int             total = 0;
  int             bad = 0;
  logic [1:0]     g;

  axi_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .m_req_i(m_req),
    .m_rsp_o(m_rsp),
    .s_req_o(s_req),
    .s_rsp_i(s_rsp),
    .gnt_o  (gnt),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [1:0] gg);
    int n = 0;
    while (gnt == 2'b00 && n < 8) begin
      tick();
      n++;
    end
    gg = gnt;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (gnt != 2'b00 && n < 8) begin
      tick();
      n++;
    end
    chk("idle_after_txn", 64'(gnt), 64'(2'b00));
  endtask

  initial begin
    rst = 1'b0;
    m_req = '0;
    s_rsp = '0;
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'(2'b00));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_sreq", 64'(s_req), 64'(0));
    chk("rst_mrsp", 64'(m_rsp), 64'(0));
    rst = 1'b1;
    tick();

    // M0 read, slave answers 3 cycles into the data phase
    m_req[0].ar_valid = 1'b1;
    m_req[0].ar_addr  = 32'h8000_0000;
    m_req[0].r_ready  = 1'b1;
    #1;
    chk("rd_idle_no_fwd", 64'(s_req.ar_valid), 64'(1'b0));
    tick();
    chk("rd_gnt", 64'(gnt), 64'(2'b01));
    chk("rd_busy", 64'(busy), 64'(1'b1));
    chk("rd_ar_valid", 64'(s_req.ar_valid), 64'(1'b1));
    chk("rd_ar_addr", 64'(s_req.ar_addr), 64'(32'h8000_0000));
    s_rsp.ar_ready = 1'b1;
    #1;
    chk("rd_ar_ready_m0", 64'(m_rsp[0].ar_ready), 64'(1'b1));
    tick();
    m_req[0].ar_valid = 1'b0;
    s_rsp.ar_ready = 1'b0;
    #1;
    chk("rd_r_ready_fwd", 64'(s_req.r_ready), 64'(1'b1));
    chk("rd_no_early_r", 64'(m_rsp[0].r_valid), 64'(1'b0));
    tick();
    tick();
    s_rsp.r_valid = 1'b1;
    s_rsp.r_data  = 32'hDEAD_BEEF;
    s_rsp.r_resp  = RESP_OKAY;
    #1;
    chk("rd_r_valid", 64'(m_rsp[0].r_valid), 64'(1'b1));
    chk("rd_r_data", 64'(m_rsp[0].r_data), 64'(32'hDEAD_BEEF));
    chk("rd_r_resp", 64'(m_rsp[0].r_resp), 64'(RESP_OKAY));
    chk("rd_m1_quiet", 64'(m_rsp[1]), 64'(0));
    tick();
    s_rsp.r_valid = 1'b0;
    chk("rd_gnt_clear", 64'(gnt), 64'(2'b00));
    chk("rd_busy_clear", 64'(busy), 64'(1'b0));

    // M1 write, W two cycles ahead of AW
    m_req[1].w_valid = 1'b1;
    m_req[1].w_data  = 32'h1234_5678;
    m_req[1].w_strb  = 4'b0011;
    m_req[1].b_ready = 1'b1;
    tick();
    chk("wr_gnt", 64'(gnt), 64'(2'b10));
    chk("wr_w_valid", 64'(s_req.w_valid), 64'(1'b1));
    chk("wr_aw_idle", 64'(s_req.aw_valid), 64'(1'b0));
    chk("wr_w_data", 64'(s_req.w_data), 64'(32'h1234_5678));
    chk("wr_w_strb", 64'(s_req.w_strb), 64'(4'b0011));
    s_rsp.w_ready = 1'b1;
    #1;
    chk("wr_w_ready_m1", 64'(m_rsp[1].w_ready), 64'(1'b1));
    chk("wr_w_ready_m0", 64'(m_rsp[0].w_ready), 64'(1'b0));
    tick();
    m_req[1].w_valid = 1'b0;
    s_rsp.w_ready = 1'b0;
    m_req[1].aw_valid = 1'b1;
    m_req[1].aw_addr  = 32'h8000_0010;
    #1;
    chk("wr_still_wr", 64'(s_req.b_ready), 64'(1'b0));
    chk("wr_aw_valid", 64'(s_req.aw_valid), 64'(1'b1));
    chk("wr_aw_addr", 64'(s_req.aw_addr), 64'(32'h8000_0010));
    s_rsp.aw_ready = 1'b1;
    tick();
    m_req[1].aw_valid = 1'b0;
    s_rsp.aw_ready = 1'b0;
    #1;
    chk("wr_b_ready", 64'(s_req.b_ready), 64'(1'b1));
    s_rsp.b_valid = 1'b1;
    s_rsp.b_resp  = RESP_OKAY;
    #1;
    chk("wr_b_m1", 64'(m_rsp[1].b_valid), 64'(1'b1));
    chk("wr_b_m0", 64'(m_rsp[0].b_valid), 64'(1'b0));
    tick();
    s_rsp.b_valid = 1'b0;
    chk("wr_idle", 64'(busy), 64'(1'b0));

    // M0 write with AW and W completing together, slave returns SLVERR
    s_rsp.aw_ready = 1'b1;
    s_rsp.w_ready  = 1'b1;
    m_req[0].aw_valid = 1'b1;
    m_req[0].aw_addr  = 32'h8000_0020;
    m_req[0].w_valid  = 1'b1;
    m_req[0].w_data   = 32'hCAFE_F00D;
    m_req[0].w_strb   = 4'b1111;
    m_req[0].b_ready  = 1'b1;
    tick();
    chk("sc_gnt", 64'(gnt), 64'(2'b01));
    chk("sc_aw_w", 64'({s_req.aw_valid, s_req.w_valid}), 64'(2'b11));
    tick();
    m_req[0].aw_valid = 1'b0;
    m_req[0].w_valid  = 1'b0;
    s_rsp.aw_ready = 1'b0;
    s_rsp.w_ready  = 1'b0;
    #1;
    chk("sc_wr_resp", 64'(s_req.b_ready), 64'(1'b1));
    s_rsp.b_valid = 1'b1;
    s_rsp.b_resp  = RESP_SLVERR;
    #1;
    chk("sc_b_resp", 64'(m_rsp[0].b_resp), 64'(RESP_SLVERR));
    tick();
    s_rsp.b_valid = 1'b0;
    chk("sc_idle", 64'(gnt), 64'(2'b00));

    // M1 raises both read and write: read first, write on the next grant
    m_req[1].ar_valid = 1'b1;
    m_req[1].ar_addr  = 32'h8000_0040;
    m_req[1].r_ready  = 1'b1;
    m_req[1].aw_valid = 1'b1;
    m_req[1].w_valid  = 1'b1;
    tick();
    chk("rw_read_first", 64'({s_req.ar_valid, s_req.aw_valid}), 64'(2'b10));
    s_rsp.ar_ready = 1'b1;
    tick();
    m_req[1].ar_valid = 1'b0;
    s_rsp.ar_ready = 1'b0;
    s_rsp.r_valid  = 1'b1;
    tick();
    s_rsp.r_valid = 1'b0;
    chk("rw_gap", 64'(gnt), 64'(2'b00));
    tick();
    chk("rw_write_gnt", 64'(gnt), 64'(2'b10));
    chk("rw_write_fwd", 64'({s_req.aw_valid, s_req.w_valid}), 64'(2'b11));
    s_rsp.aw_ready = 1'b1;
    s_rsp.w_ready  = 1'b1;
    tick();
    m_req[1].aw_valid = 1'b0;
    m_req[1].w_valid  = 1'b0;
    s_rsp.aw_ready = 1'b0;
    s_rsp.w_ready  = 1'b0;
    s_rsp.b_valid  = 1'b1;
    tick();
    s_rsp.b_valid = 1'b0;
    chk("rw_done", 64'(busy), 64'(1'b0));

    // M0 read interrupted by reset in the data phase
    m_req[0].ar_valid = 1'b1;
    tick();
    s_rsp.ar_ready = 1'b1;
    tick();
    m_req[0].ar_valid = 1'b0;
    s_rsp.ar_ready = 1'b0;
    #1;
    chk("mid_in_rd_data", 64'(s_req.r_ready), 64'(1'b1));
    rst = 1'b0;
    tick();
    chk("mid_busy", 64'(busy), 64'(1'b0));
    chk("mid_gnt", 64'(gnt), 64'(2'b00));
    chk("mid_sreq", 64'(s_req), 64'(0));

    // contention from reset release: strict alternation starting at M0
    rst = 1'b1;
    m_req[0].ar_valid = 1'b1;
    m_req[1].ar_valid = 1'b1;
    s_rsp.ar_ready = 1'b1;
    s_rsp.r_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      chk("rr_order", 64'(g), 64'((i % 2) ? 2'b10 : 2'b01));
      chk("rr_other_quiet", 64'((i % 2) ? m_rsp[0] : m_rsp[1]), 64'(0));
      wait_idle();
    end
    m_req = '0;
    s_rsp = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- 2:1 AXI4-lite arbiter sharing the single memory slave (axi_slave) between the core's instruction-fetch master (M0) and load/store master (M1).
- Sits between core master ports and the RAM in top.
- One transaction outstanding at a time; grant held from request until response handshake.
- Round-robin fairness between masters.

Parameters:
- ADDR_W, 32, address width of AR/AW channels.
- DATA_W, 32, data width; wstrb is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low (asserted when rst==0).
- m_req_i  in  2 x axi_req_t  master requests; index 0 = IFU, 1 = LSU.
- m_rsp_o  out  2 x axi_rsp_t  responses to masters.
- s_req_o  out  axi_req_t  request to memory slave.
- s_rsp_i  in  axi_rsp_t  response from memory slave.
- gnt_o  out  2  one-hot current grant; 0 when idle.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP.
- Reset values:
  - state = IDLE, gnt_o = 0, busy_o = 0.
  - last_gnt = 1, so M0 wins the first tie.
  - aw_done = w_done = 0.
  - All s_req_o valid/ready fields 0; all m_rsp_o ready/valid fields 0.
- Request from master k = ar_valid | aw_valid | w_valid.
- IDLE:
  - Exactly one requester: select it.
  - Both requesting: select the master != last_gnt.
  - For the selected master, ar_valid present -> RD_ADDR; otherwise -> WR (read wins when a master raises both).
  - Register gnt and update last_gnt.
  - Arbitration latency is 1 cycle: no channel is forwarded in IDLE.
- While granted to k:
  - Forward only k's channel fields combinationally (req to s_req_o, rsp to m_rsp_o[k]).
  - Only the channels of the current state are forwarded; all other valid/ready are forced 0.
  - The non-granted master sees all ready/valid = 0 and its signals are ignored.
- RD_ADDR: forward AR; on s ar_valid & ar_ready -> RD_DATA.
- RD_DATA: forward R; on r_valid & r_ready -> IDLE, gnt cleared.
- WR:
  - Forward AW while !aw_done and W while !w_done.
  - Set each done flag on its handshake; AW and W may complete in either order or the same cycle.
  - When both flags are set (including same-cycle completion) -> WR_RESP.
- WR_RESP: forward B; on b_valid & b_ready -> IDLE; clear done flags, clear gnt.
- Back-to-back requests:
  - Minimum 1 IDLE cycle between transactions; no combinational re-grant.
  - A master holding valid continuously while the other also requests alternates with it strictly.
- Responses are passed through unchanged, including r_resp/b_resp errors; the arbiter never generates responses.
- Data, address and strobe are passed bit-exact; no width conversion.
- Reset mid-operation: return to the reset state immediately; an in-flight slave handshake is abandoned. The system reset covers the slave too.
- Masters must keep valid/payload stable until ready (AXI rule); the arbiter does not latch payloads.

Decomposition:
- Shared package (typedefs):
  - axi_req_t = {ar_valid, ar_addr[ADDR_W], r_ready, aw_valid, aw_addr, w_valid, w_data[DATA_W], w_strb, b_ready}.
  - axi_rsp_t = {ar_ready, r_valid, r_data, r_resp[2], aw_ready, w_ready, b_valid, b_resp[2]}.
  - State enum arb_state_e.
  - RESP_OKAY/RESP_SLVERR constants.
- One sub-module: rr_arb2, a 2-requester round-robin picker (req[1:0], last_gnt -> gnt one-hot); combinational, owned by the FSM.
- Channel muxing and FSM stay in axi_arbiter.

Test Plan:
- M0 read only:
  - Stimulus: ar_addr=0x8000_0000; slave returns r_data=0xDEADBEEF after 3 cycles.
  - Required: gnt_o=01 one cycle after ar_valid; M0 receives 0xDEADBEEF with resp OKAY; gnt_o=00 the cycle after the R handshake.
- M1 write, W before AW:
  - Stimulus: w_valid with data 0x1234_5678, strb=0011; aw_valid to 0x8000_0010 two cycles later.
  - Required: slave sees both handshakes; the B handshake reaches M1 only; state returns to IDLE.
- Contention:
  - Stimulus: M0 and M1 both assert ar_valid continuously from reset release for 4 transactions.
  - Required: grant order M0, M1, M0, M1; M1 ready fields stay 0 while M0 is granted.
- Same-cycle AW/W with slave ready immediately:
  - Required: WR -> WR_RESP in one cycle; b_resp=SLVERR from the slave is forwarded unchanged.
- Master with both ar_valid and aw_valid:
  - Required: read is serviced first, then the write in the next grant to that master (assuming no competitor).
- Reset mid-transaction:
  - Stimulus: rst=0 in RD_DATA.
  - Required: next cycle busy_o=0, gnt_o=00, all forwarded valids 0; first post-reset tie grants M0.
